// File: rtl/mem_access.sv
// Memory-access stage: single-outstanding req/ack data bus, load alignment, writeback register.
// Latency: non-memory ops 1 cycle; loads/stores 2 cycles minimum (request edge + ack edge).
// Backpressure: stall_out holds upstream from an aligned access until the cycle dbus_ack arrives.
// Optional: define MA_TIMEOUT_EN for a bus timeout that reports an access fault after TIMEOUT_CYCLES.
module mem_access #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  load_op,
    input  logic [2:0]  store_op,
    input  logic [63:0] pc,
    input  logic [4:0]  rd,
    input  logic [63:0] result,
    input  logic [63:0] data2,
    output logic        stall_out,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [63:0] dbus_addr,
    output logic [63:0] dbus_wdata,
    output logic [7:0]  dbus_wmask,
    input  logic        dbus_ack,
    input  logic [63:0] dbus_rdata,
    output logic [4:0]  ma_rd,
    output logic [63:0] ma_data,
    output logic        misalign_en,
    output logic [63:0] misalign_addr,
    output logic [63:0] wb_pc,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data
);

    // A zero-cycle timeout has no meaning; reject it when the design is built.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_access: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef MA_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ERR = 2'd2} state_t;
`else
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
`endif

    state_t state, state_nxt;

    logic        is_load;
    logic        is_store;
    logic        is_mem;
    logic [1:0]  acc_lg;
    logic        misaligned;
    logic [2:0]  off;
    logic [63:0] st_wdata;
    logic [7:0]  st_wmask;
    logic [63:0] shifted;
    logic [63:0] load_ext;
    logic        tmo_hit;

    assign off = result[2:0];

    // Decode the op: access size, alignment, store lanes and load extension.
    always_comb begin
        is_load    = (load_op != 3'd0);
        is_store   = !is_load && (store_op >= 3'd1) && (store_op <= 3'd4);
        is_mem     = is_load || is_store;
        acc_lg     = 2'd0;
        st_wdata   = 64'd0;
        st_wmask   = 8'd0;
        if (is_load) begin
            case (load_op)
                3'd1, 3'd5: acc_lg = 2'd0;
                3'd2, 3'd6: acc_lg = 2'd1;
                3'd3, 3'd7: acc_lg = 2'd2;
                default:    acc_lg = 2'd3;
            endcase
        end else begin
            case (store_op)
                3'd1: begin
                    acc_lg   = 2'd0;
                    st_wdata = {8{data2[7:0]}};
                    st_wmask = 8'h01 << off;
                end
                3'd2: begin
                    acc_lg   = 2'd1;
                    st_wdata = {4{data2[15:0]}};
                    st_wmask = 8'h03 << off;
                end
                3'd3: begin
                    acc_lg   = 2'd2;
                    st_wdata = {2{data2[31:0]}};
                    st_wmask = 8'h0F << off;
                end
                3'd4: begin
                    acc_lg   = 2'd3;
                    st_wdata = data2;
                    st_wmask = 8'hFF;
                end
                default: acc_lg = 2'd0;
            endcase
        end
        case (acc_lg)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = off[0];
            2'd2:    misaligned = |off[1:0];
            default: misaligned = |off;
        endcase
        shifted = dbus_rdata >> {off, 3'b000};
        case (load_op)
            3'd1:    load_ext = {{56{shifted[7]}},  shifted[7:0]};
            3'd2:    load_ext = {{48{shifted[15]}}, shifted[15:0]};
            3'd3:    load_ext = {{32{shifted[31]}}, shifted[31:0]};
            3'd5:    load_ext = {56'd0, shifted[7:0]};
            3'd6:    load_ext = {48'd0, shifted[15:0]};
            3'd7:    load_ext = {32'd0, shifted[31:0]};
            default: load_ext = shifted;
        endcase
    end

`ifdef MA_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;

    // Count BUSY cycles without ack; restarts on every new access.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == BUSY && !dbus_ack) begin
            tmo_cnt <= tmo_cnt + CW'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_hit = (state == BUSY) && !dbus_ack && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, stall and forwarding outputs.
    always_comb begin
        state_nxt = state;
        stall_out = 1'b0;
        ma_rd     = 5'd0;
        ma_data   = 64'd0;
        case (state)
            IDLE: begin
                if (!is_mem) begin
                    ma_rd   = rd;
                    ma_data = result;
                end else if (!misaligned) begin
                    stall_out = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                stall_out = !dbus_ack;
                if (dbus_ack) begin
                    state_nxt = IDLE;
                    if (is_load) begin
                        ma_rd   = rd;
                        ma_data = load_ext;
                    end
                end else if (tmo_hit) begin
`ifdef MA_TIMEOUT_EN
                    state_nxt = ERR;
`endif
                end
            end
`ifdef MA_TIMEOUT_EN
            ERR: begin
                state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Bus request fields, fault report and writeback registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dbus_req      <= 1'b0;
            dbus_we       <= 1'b0;
            dbus_addr     <= 64'd0;
            dbus_wdata    <= 64'd0;
            dbus_wmask    <= 8'd0;
            misalign_en   <= 1'b0;
            misalign_addr <= 64'd0;
            wb_pc         <= 64'd0;
            wb_rd         <= 5'd0;
            wb_data       <= 64'd0;
        end else begin
            misalign_en <= 1'b0;
            case (state)
                IDLE: begin
                    wb_pc <= pc;
                    if (!is_mem) begin
                        wb_rd   <= rd;
                        wb_data <= result;
                    end else if (misaligned) begin
                        misalign_en   <= 1'b1;
                        misalign_addr <= result;
                        wb_rd         <= 5'd0;
                        wb_data       <= 64'd0;
                    end else begin
                        dbus_req   <= 1'b1;
                        dbus_we    <= is_store;
                        dbus_addr  <= {result[63:3], 3'b000};
                        dbus_wdata <= st_wdata;
                        dbus_wmask <= st_wmask;
                        wb_rd      <= 5'd0;
                        wb_data    <= 64'd0;
                    end
                end
                BUSY: begin
                    if (dbus_ack) begin
                        dbus_req <= 1'b0;
                        wb_pc    <= pc;
                        wb_rd    <= is_load ? rd : 5'd0;
                        wb_data  <= is_load ? load_ext : 64'd0;
                    end else begin
                        // Bubble into writeback while waiting on the bus.
                        wb_rd <= 5'd0;
                        if (tmo_hit) begin
                            dbus_req <= 1'b0;
                        end
                    end
                end
                default: begin
                    // Timed-out access is reported through the fault outputs.
                    misalign_en   <= 1'b1;
                    misalign_addr <= result;
                    wb_pc         <= pc;
                    wb_rd         <= 5'd0;
                    wb_data       <= 64'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus randomized ops against a reference model.
module tb_mem_access;

    logic        clk;
    logic        rst_n;
    logic [2:0]  load_op;
    logic [2:0]  store_op;
    logic [63:0] pc;
    logic [4:0]  rd;
    logic [63:0] result;
    logic [63:0] data2;
    logic        stall_out;
    logic        dbus_req;
    logic        dbus_we;
    logic [63:0] dbus_addr;
    logic [63:0] dbus_wdata;
    logic [7:0]  dbus_wmask;
    logic        dbus_ack;
    logic [63:0] dbus_rdata;
    logic [4:0]  ma_rd;
    logic [63:0] ma_data;
    logic        misalign_en;
    logic [63:0] misalign_addr;
    logic [63:0] wb_pc;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;

    int errors = 0;
    int checks = 0;

    mem_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .load_op(load_op), .store_op(store_op),
        .pc(pc), .rd(rd), .result(result), .data2(data2), .stall_out(stall_out),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_wmask(dbus_wmask), .dbus_ack(dbus_ack),
        .dbus_rdata(dbus_rdata), .ma_rd(ma_rd), .ma_data(ma_data),
        .misalign_en(misalign_en), .misalign_addr(misalign_addr),
        .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bytes touched by the op; 0 means not a memory access. A load wins over a store.
    function automatic int acc_bytes(input logic [2:0] lop, input logic [2:0] sop);
        if (lop != 3'd0) begin
            if (lop == 3'd1 || lop == 3'd5) return 1;
            if (lop == 3'd2 || lop == 3'd6) return 2;
            if (lop == 3'd3 || lop == 3'd7) return 4;
            return 8;
        end
        if (sop >= 3'd1 && sop <= 3'd4) return 1 << (sop - 3'd1);
        return 0;
    endfunction

    function automatic logic [63:0] byte_mask(input int n);
        if (n >= 8) return '1;
        return (64'd1 << (8 * n)) - 64'd1;
    endfunction

    function automatic logic [63:0] ref_load(input logic [2:0] lop, input logic [63:0] addr,
                                             input logic [63:0] rdata);
        int n;
        logic [63:0] m;
        logic [63:0] v;
        n = acc_bytes(lop, 3'd0);
        m = byte_mask(n);
        v = (rdata >> (8 * int'(addr % 8))) & m;
        if (lop >= 3'd1 && lop <= 3'd3 && v[8*n-1]) v = v | ~m;
        return v;
    endfunction

    function automatic logic [7:0] ref_wmask(input int n, input logic [63:0] addr);
        logic [15:0] m;
        m = ((16'd1 << n) - 16'd1) << (addr % 8);
        return m[7:0];
    endfunction

    function automatic logic [63:0] ref_wdata(input int n, input logic [63:0] d);
        logic [63:0] w;
        w = 64'd0;
        for (int i = 0; i < 8 / n; i++) w = w | ((d & byte_mask(n)) << (8 * n * i));
        return w;
    endfunction

    // Drives one instruction through the stage and checks every visible response.
    task automatic run_op(input logic [2:0] lop, input logic [2:0] sop, input logic [4:0] r,
                          input logic [63:0] res, input logic [63:0] d2,
                          input logic [63:0] rdata, input int delay, input logic idle_ack);
        int n;
        logic [63:0] p;
        n = acc_bytes(lop, sop);
        p = {$urandom, $urandom};
        load_op = lop; store_op = sop; rd = r; result = res; data2 = d2; pc = p;
        dbus_ack = 1'b0; dbus_rdata = rdata;
        if (n == 0) begin
            dbus_ack = idle_ack;
            #1;
            chk("alu_stall", 64'(stall_out), 64'd0);
            chk("alu_ma_rd", 64'(ma_rd), 64'(r));
            chk("alu_ma_data", ma_data, res);
            tick();
            dbus_ack = 1'b0;
            chk("alu_req", 64'(dbus_req), 64'd0);
            chk("alu_wb_rd", 64'(wb_rd), 64'(r));
            chk("alu_wb_data", wb_data, res);
            chk("alu_wb_pc", wb_pc, p);
        end else if ((res % n) != 0) begin
            #1;
            chk("mis_stall", 64'(stall_out), 64'd0);
            tick();
            chk("mis_req", 64'(dbus_req), 64'd0);
            chk("mis_en", 64'(misalign_en), 64'd1);
            chk("mis_addr", misalign_addr, res);
            chk("mis_wb_rd", 64'(wb_rd), 64'd0);
            load_op = 3'd0; store_op = 3'd0; rd = 5'd0;
            tick();
            chk("mis_pulse_end", 64'(misalign_en), 64'd0);
        end else begin
            #1;
            chk("mem_stall_idle", 64'(stall_out), 64'd1);
            chk("mem_ma_rd", 64'(ma_rd), 64'd0);
            tick();
            for (int i = 0; i <= delay; i++) begin
                chk("mem_req", 64'(dbus_req), 64'd1);
                chk("mem_we", 64'(dbus_we), 64'(lop == 3'd0));
                chk("mem_addr", dbus_addr, {res[63:3], 3'b000});
                if (lop == 3'd0) begin
                    chk("mem_wmask", 64'(dbus_wmask), 64'(ref_wmask(n, res)));
                    chk("mem_wdata", dbus_wdata, ref_wdata(n, d2));
                end
                if (i < delay) begin
                    chk("mem_stall_wait", 64'(stall_out), 64'd1);
                    tick();
                end
            end
            dbus_ack = 1'b1;
            #1;
            chk("mem_stall_ack", 64'(stall_out), 64'd0);
            tick();
            dbus_ack = 1'b0;
            chk("mem_req_drop", 64'(dbus_req), 64'd0);
            chk("mem_wb_pc", wb_pc, p);
            chk("mem_wb_rd", 64'(wb_rd), (lop != 3'd0) ? 64'(r) : 64'd0);
            if (lop != 3'd0) chk("mem_wb_data", wb_data, ref_load(lop, res, rdata));
        end
    endtask

    initial begin
        logic [2:0]  lop, sop;
        logic [63:0] res;
        int          kind, n;

        rst_n = 1'b0; load_op = 3'd0; store_op = 3'd0; pc = 64'd0; rd = 5'd0;
        result = 64'd0; data2 = 64'd0; dbus_ack = 1'b0; dbus_rdata = 64'd0;
        repeat (3) tick();
        chk("rst_req", 64'(dbus_req), 64'd0);
        chk("rst_we", 64'(dbus_we), 64'd0);
        chk("rst_addr", dbus_addr, 64'd0);
        chk("rst_wdata", dbus_wdata, 64'd0);
        chk("rst_wmask", 64'(dbus_wmask), 64'd0);
        chk("rst_wb_pc", wb_pc, 64'd0);
        chk("rst_wb_rd", 64'(wb_rd), 64'd0);
        chk("rst_wb_data", wb_data, 64'd0);
        chk("rst_mis_en", 64'(misalign_en), 64'd0);
        chk("rst_mis_addr", misalign_addr, 64'd0);
        chk("rst_stall", 64'(stall_out), 64'd0);
        rst_n = 1'b1;
        tick();

        // ALU pass-through.
        run_op(3'd0, 3'd0, 5'd5, 64'h1234, 64'd0, 64'd0, 0, 1'b0);
        chk("alu_wb_rd_5", 64'(wb_rd), 64'd5);
        chk("alu_wb_data_1234", wb_data, 64'h1234);

        // LB / LBU with ack three cycles after the request.
        run_op(3'd1, 3'd0, 5'd9, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 3, 1'b0);
        chk("lb_addr", dbus_addr, 64'h1000);
        chk("lb_data", wb_data, 64'hFFFF_FFFF_FFFF_FF80);
        run_op(3'd5, 3'd0, 5'd9, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 3, 1'b0);
        chk("lbu_data", wb_data, 64'h80);

        // SH into the top halfword lane.
        run_op(3'd0, 3'd2, 5'd4, 64'h2006, 64'hAABB, 64'd0, 1, 1'b0);
        chk("sh_wb_rd", 64'(wb_rd), 64'd0);

        // Misaligned LW.
        run_op(3'd3, 3'd0, 5'd6, 64'h3002, 64'd0, 64'd0, 0, 1'b0);

        // Ack while idle is ignored; reserved store op acts as no op.
        run_op(3'd0, 3'd6, 5'd11, 64'h77, 64'd0, 64'd0, 0, 1'b1);

        // Reset in the middle of an access.
        load_op = 3'd4; store_op = 3'd0; rd = 5'd7; result = 64'h5000;
        tick();
        chk("rstmid_req_up", 64'(dbus_req), 64'd1);
        rst_n = 1'b0; load_op = 3'd0; rd = 5'd0; result = 64'd0;
        tick();
        chk("rstmid_req", 64'(dbus_req), 64'd0);
        chk("rstmid_stall", 64'(stall_out), 64'd0);
        chk("rstmid_wb_rd", 64'(wb_rd), 64'd0);
        rst_n = 1'b1;
        run_op(3'd0, 3'd0, 5'd3, 64'h55, 64'd0, 64'd0, 0, 1'b1);

`ifdef MA_TIMEOUT_EN
        // LD with no ack: request lives exactly TIMEOUT_CYCLES cycles, then a fault pulse.
        load_op = 3'd4; store_op = 3'd0; rd = 5'd8; result = 64'h4000;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("tmo_req_held", 64'(dbus_req), 64'd1);
            tick();
        end
        chk("tmo_req_drop", 64'(dbus_req), 64'd0);
        chk("tmo_err_stall", 64'(stall_out), 64'd0);
        tick();
        chk("tmo_fault", 64'(misalign_en), 64'd1);
        chk("tmo_fault_addr", misalign_addr, 64'h4000);
        chk("tmo_wb_rd", 64'(wb_rd), 64'd0);
        load_op = 3'd0;
        tick();
        chk("tmo_fault_end", 64'(misalign_en), 64'd0);
        run_op(3'd0, 3'd0, 5'd2, 64'h99, 64'd0, 64'd0, 0, 1'b0);
`endif

        // Randomized mix of ALU ops, loads and stores.
        for (int t = 0; t < 80; t++) begin
            kind = $urandom_range(0, 9);
            lop = 3'd0;
            sop = 3'd0;
            if (kind <= 2) begin
                sop = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(5, 7)) : 3'd0;
            end else if (kind <= 6) begin
                lop = 3'($urandom_range(1, 7));
                if ($urandom_range(0, 4) == 0) sop = 3'($urandom_range(1, 4));
            end else begin
                sop = 3'($urandom_range(1, 4));
            end
            res = {$urandom, $urandom};
            n = acc_bytes(lop, sop);
            if (n != 0 && $urandom_range(0, 3) != 0) res = res & ~64'(n - 1);
            run_op(lop, sop, 5'($urandom_range(0, 31)), res, {$urandom, $urandom},
                   {$urandom, $urandom}, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access (MA) stage; consumes the execute stage outputs: io load/store op, pc, rd, result (address or ALU value) and data2 (store data).
- Drives a single-outstanding data bus with a req/ack handshake and aligns load data.
- Produces the MA forwarding pair (ma_rd/ma_data) and registered writeback outputs.
- Stalls upstream while a bus access is pending.

Parameters:
- TIMEOUT_CYCLES, 16, bus cycles without ack before a bus error is raised (used only with MA_TIMEOUT_EN).

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- load_op  input  3  000 none, 001 LB, 010 LH, 011 LW, 100 LD, 101 LBU, 110 LHU, 111 LWU
- store_op  input  3  000 none, 001 SB, 010 SH, 011 SW, 100 SD, others reserved and treated as none
- pc  input  64  pc of instruction in MA
- rd  input  5  destination register; 0 = none
- result  input  64  ALU result or effective address
- data2  input  64  store data
- stall_out  output  1  hold execute/earlier stages
- dbus_req  output  1  bus request
- dbus_we  output  1  1 = write
- dbus_addr  output  64  doubleword-aligned address ({result[63:3],3'b0})
- dbus_wdata  output  64  lane-replicated store data
- dbus_wmask  output  8  byte enables
- dbus_ack  input  1  request complete; rdata valid on reads
- dbus_rdata  input  64  read data
- ma_rd  output  5  forwarding rd (combinational)
- ma_data  output  64  forwarding data (combinational)
- misalign_en  output  1  one-cycle misaligned-access pulse
- misalign_addr  output  64  faulting address
- wb_pc  output  64  registered pc to writeback
- wb_rd  output  5  registered rd to writeback
- wb_data  output  64  registered writeback data

Behaviour:
- Reset: state IDLE. All outputs 0: dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wmask, wb_pc, wb_rd, wb_data, misalign_en, misalign_addr, stall_out.
- Reset mid-access drops dbus_req the next cycle. Any late ack is ignored.
- FSM: IDLE, BUSY (and ERR only with the optional feature).
- Non-memory op in IDLE:
  - Next edge: wb_pc<=pc, wb_rd<=rd, wb_data<=result.
  - ma_rd=rd, ma_data=result. stall_out=0.
- Load or store in IDLE:
  - Misaligned if the address offset is not a multiple of the access size (H: a[0]; W: a[1:0]; D: a[2:0]).
  - Misaligned: no bus request, stall_out=0. Next edge: misalign_en<=1 for one cycle, misalign_addr<=result, wb_rd<=0.
  - Aligned: stall_out=1 and ma_rd=0. Next edge: state->BUSY, dbus_req<=1, with dbus_we, dbus_addr, dbus_wdata and dbus_wmask registered.
- BUSY:
  - dbus_req and all bus fields are held stable until the cycle dbus_ack=1.
  - stall_out = !dbus_ack, combinational, so execute advances on the ack edge.
  - On the ack edge: state->IDLE, dbus_req<=0, wb_pc<=pc.
  - Loads: wb_rd<=rd, wb_data<=extended load data.
  - Stores: wb_rd<=0.
  - Minimum load/store latency is 2 cycles: op arrives, then req with ack in the same cycle.
- Store data and mask:
  - wdata: SB replicates data2[7:0] x8; SH replicates [15:0] x4; SW replicates [31:0] x2; SD is data2.
  - wmask: SB 8'h01<<a[2:0]; SH 8'h03<<a[2:0]; SW 8'h0F<<a[2:0]; SD 8'hFF.
- Load data: shifted = dbus_rdata >> (a[2:0]*8). Sign-extend for LB/LH/LW; zero-extend for LBU/LHU/LWU; LD is unchanged.
- Loads to rd=0 still access the bus; writeback rd stays 0.
- If load_op and store_op are both nonzero, the load takes priority.
- dbus_ack outside BUSY is ignored.

Optional Feature:
- MA_TIMEOUT_EN defined:
  - A counter runs in BUSY. After TIMEOUT_CYCLES cycles without ack: dbus_req<=0, state->ERR.
  - ERR lasts one cycle: misalign_en<=1, misalign_addr<=result (reported as an access fault), wb_rd<=0, stall_out=0, then IDLE.
- MA_TIMEOUT_EN undefined: no counter and no ERR state; BUSY waits indefinitely.

Test Plan:
- ALU pass-through:
  - Stimulus: rd=5, result=0x1234, no op.
  - Response: ma_rd=5, ma_data=0x1234 in the same cycle; wb_rd=5, wb_data=0x1234 one cycle later; stall_out never set.
- LB with delayed ack:
  - Stimulus: result=0x1003, rdata=0x00000000_80000000, ack 3 cycles after req.
  - Response: dbus_addr=0x1000; stall held 4 cycles; wb_data=0xFFFF_FFFF_FFFF_FF80. The same access with LBU gives 0x80.
- SH:
  - Stimulus: result=0x2006, data2=0xAABB.
  - Response: dbus_we=1, wmask=8'hC0, wdata=0xAABB_AABB_AABB_AABB, wb_rd=0 after ack.
- LW misaligned:
  - Stimulus: result=0x3002.
  - Response: no dbus_req; misalign_en pulses 1 cycle; misalign_addr=0x3002.
- Reset mid-access:
  - Stimulus: rst_n=0 during BUSY.
  - Response: next cycle dbus_req=0, stall_out=0, wb_rd=0; a subsequent ack is ignored.
- Timeout (with MA_TIMEOUT_EN, TIMEOUT_CYCLES=4):
  - Stimulus: LD with ack never asserted.
  - Response: req drops after 4 cycles; misalign_en pulses once; stage returns to IDLE.
